// File: rtl/ahb_mem_responder.sv
// AHB-Lite memory responder: byte-organised storage with strobed writes,
// programmable wait states and a two-cycle ERROR response for illegal transfers.
module ahb_mem_responder #(
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic        HREADYIN,
  input  logic [31:0] HWDATA,
  input  logic [3:0]  WSTRB,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int WW = AW - 2;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t          state, nxt, phase_st;
  logic [WW-1:0]   addr;
  logic            wr;
  logic [3:0]      cnt;
  logic            phase, accept, bad;
  logic [7:0]      mem [MEM_DEPTH];

  always_comb begin
    phase = HSEL & HREADYIN & HTRANS[1];
    bad   = (HADDR >= 32'(MEM_DEPTH)) || (HSIZE > 3'd2) ||
            (HSIZE == 3'd1 && HADDR[0]) ||
            (HSIZE == 3'd2 && HADDR[1:0] != 2'b00);
    phase_st = bad ? S_ERR1 : ((WAIT_STATES > 0) ? S_WAIT : S_DATA);
    // New address phases are only taken when no data phase is stalling the bus.
    accept = phase && (state == S_IDLE || state == S_DATA || state == S_ERR2);
    nxt = S_IDLE;
    case (state)
      S_WAIT:  nxt = (cnt == 4'd1) ? S_DATA : S_WAIT;
      S_ERR1:  nxt = S_ERR2;
      default: nxt = accept ? phase_st : S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      addr      <= '0;
      wr        <= 1'b0;
      HREADYOUT <= 1'b1;
      HRESP     <= 2'b00;
    end else begin
      state <= nxt;
      if (accept) begin
        addr <= HADDR[AW-1:2];
        wr   <= HWRITE;
        cnt  <= 4'(WAIT_STATES);
      end else if (state == S_WAIT) begin
        cnt <= cnt - 4'd1;
      end
      HREADYOUT <= !(nxt == S_WAIT || nxt == S_ERR1);
      HRESP     <= (nxt == S_ERR1 || nxt == S_ERR2) ? 2'b01 : 2'b00;
    end
  end

  // Write commits on the edge that closes the DATA cycle, so a following
  // back-to-back read of the same word already sees the new bytes.
  always_ff @(posedge HCLK) begin
    if (!HRESET && state == S_DATA && wr) begin
      for (int i = 0; i < 4; i++)
        if (WSTRB[i]) mem[{addr, 2'(i)}] <= HWDATA[8*i +: 8];
    end
  end

  always_comb begin
    HRDATA = 32'd0;
    if (state == S_DATA && !wr)
      HRDATA = {mem[{addr, 2'd3}], mem[{addr, 2'd2}], mem[{addr, 2'd1}], mem[{addr, 2'd0}]};
  end

endmodule

// File: tb/tb_ahb_mem_responder.sv
// Directed bench: one zero-wait responder and one three-wait responder on a shared bus.
module tb_ahb_mem_responder;

  logic        clk, rst, sel0, sel3, hwrite, hreadyin;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [3:0]  wstrb;
  logic [31:0] rdata0, rdata3;
  logic        ready0, ready3;
  logic [1:0]  resp0, resp3;
  int          total = 0;
  int          bad = 0;

  ahb_mem_responder #(.MEM_DEPTH(256), .WAIT_STATES(0)) dut0 (
    .HCLK(clk), .HRESET(rst), .HSEL(sel0), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HREADYIN(hreadyin), .HWDATA(hwdata),
    .WSTRB(wstrb), .HRDATA(rdata0), .HREADYOUT(ready0), .HRESP(resp0));

  ahb_mem_responder #(.MEM_DEPTH(256), .WAIT_STATES(3)) dut3 (
    .HCLK(clk), .HRESET(rst), .HSEL(sel3), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HREADYIN(hreadyin), .HWDATA(hwdata),
    .WSTRB(wstrb), .HRDATA(rdata3), .HREADYOUT(ready3), .HRESP(resp3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word0(input int a);
    return {dut0.mem[a+3], dut0.mem[a+2], dut0.mem[a+1], dut0.mem[a]};
  endfunction

  task automatic phase(input logic [31:0] a, input logic [1:0] t, input logic w, input logic [2:0] s);
    haddr = a; htrans = t; hwrite = w; hsize = s;
  endtask

  initial begin
    rst = 1'b1; sel0 = 1'b0; sel3 = 1'b0; hreadyin = 1'b1;
    haddr = '0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd2; hwdata = '0; wstrb = '0;
    {dut0.mem[19], dut0.mem[18], dut0.mem[17], dut0.mem[16]} = 32'h11223344;
    {dut0.mem[71], dut0.mem[70], dut0.mem[69], dut0.mem[68]} = 32'hA3A2A1A0;
    {dut3.mem[35], dut3.mem[34], dut3.mem[33], dut3.mem[32]} = 32'hDEADBEEF;
    {dut3.mem[39], dut3.mem[38], dut3.mem[37], dut3.mem[36]} = 32'h01020304;
    tick(); tick();
    chk("rst_ready", {31'd0, ready0}, 32'd1);
    chk("rst_resp", {30'd0, resp0}, 32'd0);
    chk("rst_rdata", rdata0, 32'd0);
    rst = 1'b0;

    // zero-wait burst of word writes
    sel0 = 1'b1; phase(32'h0, 2'b10, 1'b1, 3'd2);
    tick();
    chk("wr0_ready", {31'd0, ready0}, 32'd1);
    chk("wr0_rdata", rdata0, 32'd0);
    hwdata = 32'h03020100; wstrb = 4'hF; phase(32'h4, 2'b11, 1'b1, 3'd2);
    tick();
    chk("wr1_ready", {31'd0, ready0}, 32'd1);
    chk("wr1_resp", {30'd0, resp0}, 32'd0);
    hwdata = 32'h07060504; phase(32'h8, 2'b11, 1'b1, 3'd2);
    tick();
    chk("wr2_ready", {31'd0, ready0}, 32'd1);
    hwdata = 32'h0B0A0908; htrans = 2'b00; sel0 = 1'b0;
    tick();
    chk("mem_w0", word0(0), 32'h03020100);
    chk("mem_w4", word0(4), 32'h07060504);
    chk("mem_w8", word0(8), 32'h0B0A0908);

    // strobed write followed by back-to-back read of the same word
    sel0 = 1'b1; phase(32'h10, 2'b10, 1'b1, 3'd2);
    tick();
    hwdata = 32'hAABBCCDD; wstrb = 4'b0101; phase(32'h10, 2'b10, 1'b0, 3'd2);
    tick();
    chk("strb_rdata", rdata0, 32'h11BB33DD);
    htrans = 2'b00; sel0 = 1'b0; wstrb = 4'h0;
    tick();
    chk("idle_rdata", rdata0, 32'd0);

    // three wait states; the next phase is held with HREADYIN forced high
    sel3 = 1'b1; phase(32'h20, 2'b10, 1'b0, 3'd2);
    tick();
    phase(32'h24, 2'b10, 1'b0, 3'd2);
    chk("ws_c1_ready", {31'd0, ready3}, 32'd0);
    chk("ws_c1_resp", {30'd0, resp3}, 32'd0);
    tick();
    chk("ws_c2_ready", {31'd0, ready3}, 32'd0);
    tick();
    chk("ws_c3_ready", {31'd0, ready3}, 32'd0);
    tick();
    chk("ws_done_ready", {31'd0, ready3}, 32'd1);
    chk("ws_done_rdata", rdata3, 32'hDEADBEEF);
    tick();
    chk("ws_next_ready", {31'd0, ready3}, 32'd0);
    htrans = 2'b00;
    tick(); tick(); tick();
    chk("ws2_ready", {31'd0, ready3}, 32'd1);
    chk("ws2_rdata", rdata3, 32'h01020304);
    sel3 = 1'b0;
    tick();

    // out-of-range read, then misaligned halfword write
    sel0 = 1'b1; phase(32'h100, 2'b10, 1'b0, 3'd2);
    tick();
    chk("e1_ready", {31'd0, ready0}, 32'd0);
    chk("e1_resp", {30'd0, resp0}, 32'd1);
    hreadyin = 1'b0; phase(32'h3, 2'b10, 1'b1, 3'd1);
    tick();
    chk("e1b_ready", {31'd0, ready0}, 32'd1);
    chk("e1b_resp", {30'd0, resp0}, 32'd1);
    hreadyin = 1'b1;
    tick();
    chk("e2_ready", {31'd0, ready0}, 32'd0);
    chk("e2_resp", {30'd0, resp0}, 32'd1);
    chk("e2_rdata", rdata0, 32'd0);
    hwdata = 32'hFFFFFFFF; wstrb = 4'hF; hreadyin = 1'b0; phase(32'h0, 2'b10, 1'b0, 3'd2);
    tick();
    chk("e2b_ready", {31'd0, ready0}, 32'd1);
    chk("e2b_resp", {30'd0, resp0}, 32'd1);
    hreadyin = 1'b1;
    tick();
    chk("post_err_ready", {31'd0, ready0}, 32'd1);
    chk("post_err_resp", {30'd0, resp0}, 32'd0);
    chk("post_err_rdata", rdata0, 32'h03020100);
    htrans = 2'b00;
    tick();
    chk("err_mem_w0", word0(0), 32'h03020100);

    // read-after-write, then reset during a write data phase
    phase(32'h40, 2'b10, 1'b1, 3'd2);
    tick();
    hwdata = 32'h12345678; wstrb = 4'hF; phase(32'h40, 2'b10, 1'b0, 3'd2);
    tick();
    chk("raw_rdata", rdata0, 32'h12345678);
    phase(32'h44, 2'b10, 1'b1, 3'd2);
    tick();
    hwdata = 32'hDEADDEAD; rst = 1'b1; htrans = 2'b00; sel0 = 1'b0;
    tick();
    chk("rst_mid_ready", {31'd0, ready0}, 32'd1);
    chk("rst_mid_resp", {30'd0, resp0}, 32'd0);
    chk("rst_mid_rdata", rdata0, 32'd0);
    chk("rst_mid_mem", word0(68), 32'hA3A2A1A0);
    rst = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb_mem_responder.md
# ahb_mem_responder

AHB-Lite responder (slave) backing a byte-organised memory: accepts address phases from the DMAC master port, completes read/write data phases with programmable wait states, applies write strobes, and issues a two-cycle ERROR response for illegal transfers. It is the memory-side counterpart of the DMAC initiator. Both the source and the destination memories instantiate this block, and it is synthesisable.

## Interface
Parameters:
- MEM_DEPTH, 256: memory size in bytes; must be a multiple of 4.
- WAIT_STATES, 0: HREADYOUT-low cycles inserted per OKAY data phase; range 0..15.

Ports:
- HCLK  in  1  clock; all logic is on the rising edge.
- HRESET  in  1  reset; synchronous, active-high.
- HSEL  in  1  slave select.
- HADDR  in  32  byte address.
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  0 = byte, 1 = halfword, 2 = word.
- HREADYIN  in  1  bus ready; address phase sampled only when this is 1.
- HWDATA  in  32  write data, valid in the data phase.
- WSTRB  in  4  byte-lane write enables, valid in the data phase.
- HRDATA  out  32  read data.
- HREADYOUT  out  1  data-phase complete.
- HRESP  out  2  00 = OKAY, 01 = ERROR.

## Operation
- Storage is mem[0..MEM_DEPTH-1], 8 bits per entry, little-endian. Word at aligned address A = {mem[A+3], mem[A+2], mem[A+1], mem[A]}.
- Memory is never cleared by reset. Benches preload it hierarchically (.mem) while HRESET is high.
- Valid address phase: HSEL & HREADYIN & HTRANS[1]. On a valid phase, register HADDR[31:2], HWRITE and HSIZE, and classify the transfer.
- Classification is ERROR if any of these hold:
  - HADDR ≥ MEM_DEPTH.
  - HSIZE > 2.
  - Halfword with HADDR[0] = 1.
  - Word with HADDR[1:0] ≠ 0.
- Otherwise the transfer is OKAY.
- HTRANS IDLE or BUSY, or HSEL = 0: no data phase is created, and the response is zero-wait OKAY.
- FSM states:
  - IDLE: no pending data phase.
  - WAIT: count down WAIT_STATES.
  - DATA: completing cycle.
  - ERR1, ERR2: error response cycles.
- Transitions:
  - IDLE → WAIT on an OKAY address phase when WAIT_STATES > 0; → DATA when WAIT_STATES = 0; → ERR1 on an ERROR phase.
  - WAIT → DATA when the counter reaches 1.
  - DATA or ERR2 → next state per the address phase sampled in the same cycle, else IDLE.
  - ERR1 → ERR2 unconditionally.
- Write: at the DATA-state clock edge, lane i writes mem[{addr,2'b00}+i] ← HWDATA[8i+7:8i] when WSTRB[i] = 1. HSIZE does not gate lanes; WSTRB alone does.
- Read: in DATA, HRDATA = word at the registered word address, read combinationally from memory. HRDATA = 0 in all other states and for writes.
- ERROR transfers never modify memory.

## Timing
- Reset values: state IDLE, wait counter 0, HREADYOUT = 1, HRESP = 00, HRDATA = 0.
- Outputs are decoded from state:

| State | HREADYOUT | HRESP |
|---|---|---|
| IDLE, DATA | 1 | 00 |
| WAIT | 0 | 00 |
| ERR1 | 0 | 01 |
| ERR2 | 1 | 01 |

- OKAY latency: data phase completes WAIT_STATES + 1 cycles after the address-phase edge. With WAIT_STATES = 0, back-to-back NONSEQ/SEQ transfers complete one per cycle.
- Pipelining: the address phase for transfer N+1 is sampled in the same cycle as data completion of transfer N (DATA or ERR2 with HREADYIN = 1). In WAIT or ERR1, HREADYIN is low on a real bus; if HREADYIN is forced to 1 there, new address phases are still ignored.
- Read-after-write to the same address in consecutive transfers: the read returns the newly written data, because the write commits at the edge that starts the read data phase.
- HSEL low during a pending data phase: the data phase still completes normally.
- HRESET asserted mid-transfer: at that edge the FSM returns to IDLE, the pending write is dropped (memory unchanged), and outputs take reset values on the next cycle.

## Test plan
- Word writes, WAIT_STATES = 0: NONSEQ writes to 0x0, SEQ to 0x4, 0x8 with HWDATA 0x03020100, 0x07060504, 0x0B0A0908 and WSTRB = 1111 → HREADYOUT stays 1, HRESP = 00, mem[0..11] = 0x00..0x0B.
- Strobes: write 0xAABBCCDD to 0x10 with WSTRB = 0101 over preloaded 0x11223344 → word at 0x10 reads 0x11BB33DD.
- Wait states, WAIT_STATES = 3: read of 0x20 (preloaded 0xDEADBEEF):
  - HREADYOUT is 0 for 3 cycles, then 1 with HRDATA = 0xDEADBEEF.
  - The next address phase is sampled only on the completing cycle.
- Error: read of 0x100 with MEM_DEPTH = 256, then a halfword write to 0x3:
  - Each gives HREADYOUT/HRESP = 0/01 then 1/01.
  - Memory is unchanged; the following OKAY transfer completes normally.
- Read-after-write plus reset: write 0x12345678 to 0x40, then a back-to-back read of 0x40 → HRDATA = 0x12345678. Then start a write to 0x44 and assert HRESET during its data phase → mem[0x44..0x47] unchanged, HREADYOUT = 1, HRESP = 00, HRDATA = 0 after reset.
